// File: rtl/useq_decoder.sv
// useq_decoder: microcoded FETCH/DECODE/READ/EXEC sequencer with micro-word expansion; USEQ_PERF_EN adds instr_count
module useq_decoder #(
    parameter int DATA_W = 16,
    parameter int OPC_W = 6,
    parameter int UADDR_W = 8,
    parameter int FETCH_UADDR = 2,
    parameter logic [15:0] HALT_INSTR = 16'hFE00
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        instr,
    input  logic [39:0]        uword,
    input  logic               mem_ack,
    input  logic               stall,
    input  logic               resume,
    output logic [UADDR_W-1:0] uaddr,
    output logic               mar_ld,
    output logic               mdr_ld,
    output logic               ir_ld,
    output logic               reg_ld,
    output logic               ram_ld,
    output logic               incr_pc,
    output logic               be,
    output logic [2:0]         regr0s,
    output logic [2:0]         regr1s,
    output logic [2:0]         regws,
    output logic [1:0]         mdrs,
    output logic [1:0]         op0s,
    output logic [1:0]         op1s,
    output logic [2:0]         alufunc,
    output logic [2:0]         cond,
    output logic               cond_chk,
    output logic [DATA_W-1:0]  imm,
    output logic [2:0]         phase,
    output logic               commit,
`ifdef USEQ_PERF_EN
    output logic [31:0]        instr_count,
`endif
    output logic               halted
);
    typedef enum logic [2:0] {FETCH, DECODE, READ, EXEC, HALT} phase_t;
    localparam logic [39:0] TBL = {5'h1F, 5'h1E, 5'h1C, 5'h18, 5'h08, 5'h04, 5'h02, 5'h01};
    phase_t st, st_nx;
    logic cm, cm_nx, halt_in, live, done;
    logic [OPC_W-1:0] opc;
    logic [4:0] t;
    logic [2:0] imms;
    logic unused_bits;
    function automatic logic [2:0] sel(input logic [3:0] f, input logic [15:0] i);
        return f == 4'd8 ? i[8:6] : f == 4'd9 ? i[5:3] : f == 4'd10 ? i[2:0] :
               f == 4'd11 ? {1'b0, i[1:0]} + 3'd1 : f[2:0];
    endfunction
    assign opc = instr[15] ? OPC_W'(instr[14:9]) : OPC_W'(instr[14:13]);
    assign halt_in = st == DECODE && !cm && instr == HALT_INSTR;
    assign live = !reset && !stall && st != HALT && !halt_in;
    assign done = cm && (!uword[33] || mem_ack);
    assign unused_bits = ^uword[2:0];
    assign mar_ld = live && !cm && uword[39];
    assign mdr_ld = live && !cm && uword[37];
    assign ir_ld = live && done && uword[38];
    assign reg_ld = live && done && uword[36];
    assign ram_ld = live && done && uword[35];
    assign incr_pc = live && done && uword[34];
    assign be = live && done && uword[32];
    assign regr0s = sel(uword[31:28], instr);
    assign regr1s = sel(uword[27:24], instr);
    assign regws = sel(uword[23:20], instr);
    assign mdrs = uword[19:18];
    assign op0s = uword[14:13];
    assign op1s = uword[12:11];
    assign alufunc = uword[7:5];
    assign cond_chk = uword[8];
    assign cond = uword[10:9] == 2'd2 ? instr[2:0] : uword[10:9] == 2'd1 ? 3'd1 : 3'd0;
    assign phase = st;
    assign commit = cm;
    assign halted = st == HALT;
    assign imms = uword[17:15];
    assign t = TBL[instr[8:6]*5 +: 5];
    // micro-address per phase and immediate expansion
    always_comb begin
        uaddr = st == DECODE ? UADDR_W'(opc) :
                st == READ ? UADDR_W'(opc) + UADDR_W'(1 << OPC_W) :
                st == EXEC ? UADDR_W'(opc) + UADDR_W'(2 << OPC_W) : UADDR_W'(FETCH_UADDR);
        imm = imms == 3'd0 ? {{(DATA_W-7){instr[8]}}, instr[8:2]} :
              imms == 3'd1 ? {{(DATA_W-10){instr[12]}}, instr[12:3]} :
              imms == 3'd2 ? {{(DATA_W-13){instr[12]}}, instr[12:0]} :
              imms == 3'd3 ? {{(DATA_W-5){t[4]}}, t} :
              imms == 3'd4 ? {{(DATA_W-7){1'b0}}, instr[8:2]} : '0;
    end
    // phase/commit sequencing: stall freezes, setup is one cycle, commit waits on mem_ack when asked
    always_comb begin
        st_nx = st;
        cm_nx = cm;
        if (stall) begin
            st_nx = st;
        end else if (st == HALT) begin
            st_nx = resume ? FETCH : HALT;
        end else if (!cm) begin
            st_nx = halt_in ? HALT : st;
            cm_nx = !halt_in;
        end else if (done) begin
            cm_nx = 1'b0;
            st_nx = st == FETCH ? DECODE : st == READ ? EXEC : st == EXEC ? FETCH :
                    uword[4] ? FETCH : uword[3] ? EXEC : READ;
        end
    end
    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            st <= FETCH;
            cm <= 1'b0;
        end else begin
            st <= st_nx;
            cm <= cm_nx;
        end
    end
`ifdef USEQ_PERF_EN
    // count instructions retired into FETCH from a DECODE or EXEC commit
    always_ff @(posedge clk) begin
        if (reset)
            instr_count <= '0;
        else if (!stall && done && st_nx == FETCH && (st == DECODE || st == EXEC))
            instr_count <= instr_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_useq_decoder.sv
// tb_useq_decoder: scoreboard bench for useq_decoder driving a modelled microcode ROM
module tb_useq_decoder;
    logic clk, reset, mem_ack, stall, resume;
    logic [15:0] instr;
    logic [39:0] uword;
    logic [7:0] uaddr;
    logic mar_ld, mdr_ld, ir_ld, reg_ld, ram_ld, incr_pc, be, cond_chk, commit, halted;
    logic [2:0] regr0s, regr1s, regws, alufunc, cond, phase;
    logic [1:0] mdrs, op0s, op1s;
    logic [15:0] imm;
`ifdef USEQ_PERF_EN
    logic [31:0] instr_count;
`endif
    logic [39:0] rom [256];
    logic [19:0] obs;
    logic [19:0] sb [$];
    logic [31:0] dsb [$];
    int checks = 0, errors = 0;
    localparam logic [39:0] WF = (40'd1 << 39) | (40'd1 << 38) | (40'd1 << 34);
    localparam logic [3:0] R = 4'd8, A = 4'd4, S = 4'd2, P = 4'd1;

    useq_decoder dut (
        .clk(clk), .reset(reset), .instr(instr), .uword(uword), .mem_ack(mem_ack),
        .stall(stall), .resume(resume), .uaddr(uaddr), .mar_ld(mar_ld), .mdr_ld(mdr_ld),
        .ir_ld(ir_ld), .reg_ld(reg_ld), .ram_ld(ram_ld), .incr_pc(incr_pc), .be(be),
        .regr0s(regr0s), .regr1s(regr1s), .regws(regws), .mdrs(mdrs), .op0s(op0s),
        .op1s(op1s), .alufunc(alufunc), .cond(cond), .cond_chk(cond_chk), .imm(imm),
        .phase(phase), .commit(commit),
`ifdef USEQ_PERF_EN
        .instr_count(instr_count),
`endif
        .halted(halted)
    );

    assign uword = rom[uaddr];
    assign obs = {uaddr, phase, commit, halted, mar_ld, mdr_ld, ir_ld, reg_ld, ram_ld, incr_pc, be};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] mk(input logic [3:0] c, input logic [7:0] ua, input logic [2:0] ph,
                                       input logic cm, input logic hl, input logic [6:0] s);
        return {c, ua, ph, cm, hl, s};
    endfunction

    task automatic test_reset();
        logic [23:0] t[$];
        logic [19:0] e;
        t = '{mk(R, 8'd2, 3'd0, 1'b0, 1'b0, 7'b0000000)};
        foreach (t[i]) begin
            {reset, mem_ack, stall, resume} = t[i][23:20];
            sb.push_back(t[i][19:0]);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL reset[%0d] got %h expected %h", i, obs, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_basic();
        logic [23:0] t[$];
        logic [19:0] e;
        instr = 16'h8A00;
        reset = 1'b1;
        @(negedge clk);
        t = '{mk(0, 8'd2, 3'd0, 1'b0, 1'b0, 7'b1000000), mk(0, 8'd2, 3'd0, 1'b1, 1'b0, 7'b0010010),
              mk(0, 8'd5, 3'd1, 1'b0, 1'b0, 7'b0000000), mk(0, 8'd5, 3'd1, 1'b1, 1'b0, 7'b0000000),
              mk(0, 8'd133, 3'd3, 1'b0, 1'b0, 7'b0000000), mk(0, 8'd133, 3'd3, 1'b1, 1'b0, 7'b0001000),
              mk(0, 8'd2, 3'd0, 1'b0, 1'b0, 7'b1000000)};
        foreach (t[i]) begin
            {reset, mem_ack, stall, resume} = t[i][23:20];
            sb.push_back(t[i][19:0]);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL basic[%0d] got %h expected %h", i, obs, e); end
            @(negedge clk);
        end
`ifdef USEQ_PERF_EN
        checks++;
        if (instr_count !== 32'd1) begin errors++; $display("FAIL perf_count got %0d expected 1", instr_count); end
`endif
    endtask

    task automatic test_mem_wait();
        logic [23:0] t[$];
        logic [19:0] e;
        rom[2] = WF | (40'd1 << 33);
        instr = 16'h8A00;
        reset = 1'b1;
        @(negedge clk);
        t = '{mk(0, 8'd2, 3'd0, 1'b0, 1'b0, 7'b1000000), mk(0, 8'd2, 3'd0, 1'b1, 1'b0, 7'b0000000),
              mk(0, 8'd2, 3'd0, 1'b1, 1'b0, 7'b0000000), mk(0, 8'd2, 3'd0, 1'b1, 1'b0, 7'b0000000),
              mk(A, 8'd2, 3'd0, 1'b1, 1'b0, 7'b0010010), mk(0, 8'd5, 3'd1, 1'b0, 1'b0, 7'b0000000)};
        foreach (t[i]) begin
            {reset, mem_ack, stall, resume} = t[i][23:20];
            sb.push_back(t[i][19:0]);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL mem_wait[%0d] got %h expected %h", i, obs, e); end
            @(negedge clk);
        end
        rom[2] = WF;
    endtask

    task automatic test_halt();
        logic [23:0] t[$];
        logic [19:0] e;
        instr = 16'hFE00;
        reset = 1'b1;
        @(negedge clk);
        t = '{mk(0, 8'd2, 3'd0, 1'b0, 1'b0, 7'b1000000), mk(0, 8'd2, 3'd0, 1'b1, 1'b0, 7'b0010010),
              mk(0, 8'd63, 3'd1, 1'b0, 1'b0, 7'b0000000)};
        for (int k = 0; k < 9; k++) t.push_back(mk(A, 8'd2, 3'd4, 1'b0, 1'b1, 7'b0000000));
        t.push_back(mk(P, 8'd2, 3'd4, 1'b0, 1'b1, 7'b0000000));
        t.push_back(mk(0, 8'd2, 3'd0, 1'b0, 1'b0, 7'b1000000));
        foreach (t[i]) begin
            {reset, mem_ack, stall, resume} = t[i][23:20];
            sb.push_back(t[i][19:0]);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL halt[%0d] got %h expected %h", i, obs, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        logic [23:0] t[$];
        logic [19:0] e;
        instr = 16'h8A00;
        reset = 1'b1;
        @(negedge clk);
        t = '{mk(0, 8'd2, 3'd0, 1'b0, 1'b0, 7'b1000000), mk(0, 8'd2, 3'd0, 1'b1, 1'b0, 7'b0010010),
              mk(0, 8'd5, 3'd1, 1'b0, 1'b0, 7'b0000000), mk(0, 8'd5, 3'd1, 1'b1, 1'b0, 7'b0000000),
              mk(0, 8'd133, 3'd3, 1'b0, 1'b0, 7'b0000000)};
        for (int k = 0; k < 4; k++) t.push_back(mk(S | A, 8'd133, 3'd3, 1'b1, 1'b0, 7'b0000000));
        t.push_back(mk(0, 8'd133, 3'd3, 1'b1, 1'b0, 7'b0001000));
        t.push_back(mk(0, 8'd2, 3'd0, 1'b0, 1'b0, 7'b1000000));
        foreach (t[i]) begin
            {reset, mem_ack, stall, resume} = t[i][23:20];
            sb.push_back(t[i][19:0]);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL stall[%0d] got %h expected %h", i, obs, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_decode_fields();
        logic [2:0] ims [6] = '{3'd0, 3'd4, 3'd3, 3'd1, 3'd2, 3'd5};
        logic [15:0] ins [6] = '{16'h01FC, 16'h01FC, 16'h0140, 16'h1000, 16'h1000, 16'h1000};
        logic [15:0] exi [6] = '{16'hFFFF, 16'h007F, 16'hFFFC, 16'hFE00, 16'hF000, 16'h0000};
        logic [31:0] e, o;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rom[2] = 40'(ims[i]) << 15;
            instr = ins[i];
            dsb.push_back({16'h0, exi[i]});
            #1;
            e = dsb.pop_front();
            o = {16'h0, imm};
            checks++;
            if (o !== e) begin errors++; $display("FAIL imm[%0d] got %h expected %h", i, o, e); end
            @(negedge clk);
        end
        rom[2] = (40'd8 << 28) | (40'd11 << 24) | (40'd13 << 20) | (40'd2 << 18) | (40'd1 << 13) |
                 (40'd3 << 11) | (40'd2 << 9) | (40'd1 << 8) | (40'd5 << 5);
        instr = 16'h01AE;
        dsb.push_back({10'h0, 3'd6, 3'd3, 3'd5, 3'd6, 3'd5, 1'b1, 2'd2, 2'd1, 2'd3});
        #1;
        e = dsb.pop_front();
        o = {10'h0, regr0s, regr1s, regws, cond, alufunc, cond_chk, mdrs, op0s, op1s};
        checks++;
        if (o !== e) begin errors++; $display("FAIL selects got %h expected %h", o, e); end
        @(negedge clk);
        rom[2] = WF;
    endtask

    task automatic test_reset_mid();
        logic [23:0] t[$];
        logic [19:0] e;
        instr = 16'h0000;
        reset = 1'b1;
        @(negedge clk);
        t = '{mk(0, 8'd2, 3'd0, 1'b0, 1'b0, 7'b1000000), mk(0, 8'd2, 3'd0, 1'b1, 1'b0, 7'b0010010),
              mk(0, 8'd0, 3'd1, 1'b0, 1'b0, 7'b0000000), mk(0, 8'd0, 3'd1, 1'b1, 1'b0, 7'b0000000),
              mk(0, 8'd64, 3'd2, 1'b0, 1'b0, 7'b0100000), mk(0, 8'd64, 3'd2, 1'b1, 1'b0, 7'b0000000),
              mk(R, 8'd64, 3'd2, 1'b1, 1'b0, 7'b0000000), mk(R, 8'd2, 3'd0, 1'b0, 1'b0, 7'b0000000),
              mk(0, 8'd2, 3'd0, 1'b0, 1'b0, 7'b1000000)};
        foreach (t[i]) begin
            {reset, mem_ack, stall, resume} = t[i][23:20];
            sb.push_back(t[i][19:0]);
            #1;
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL reset_mid[%0d] got %h expected %h", i, obs, e); end
            @(negedge clk);
        end
    endtask

    initial begin
        foreach (rom[i]) rom[i] = '0;
        rom[2] = WF;
        rom[5] = 40'd1 << 3;
        rom[133] = 40'd1 << 36;
        rom[63] = 40'd1 << 39;
        rom[64] = (40'd1 << 37) | (40'd1 << 35) | (40'd1 << 33);
        reset = 1'b1;
        mem_ack = 1'b0;
        stall = 1'b0;
        resume = 1'b0;
        instr = 16'h0000;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_mem_wait();
        test_halt();
        test_stall();
        test_decode_fields();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
